// File: rtl/hazard_scheduler_pkg.sv
// hazard_scheduler_pkg
//   Shared definitions for the hazard scheduler:
//     sched_state_e  FSM state codes (RUN=0, DIV_WAIT=1, HALT=2, FLUSH=3)
//     DIV_CNT_W      width of the divide occupancy counter
//     sb_entry_t     scoreboard entry {valid, rd, is_load}
//     opcode_e       instruction opcode definitions used by the decoder
//     src_hit()      source-vs-destination match helper
package hazard_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DIV_WAIT = 2'd1,
    ST_HALT     = 2'd2,
    ST_FLUSH    = 2'd3
  } sched_state_e;

  localparam int DIV_CNT_W = 4;

  // rd is stored at a fixed width so the struct does not depend on the
  // module parameter; register addresses are zero-extended into it.
  localparam int SB_RD_W = 8;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               is_load;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '{valid: 1'b0, rd: '0, is_load: 1'b0};

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_ALU   = 4'd1,
    OP_LOAD  = 4'd2,
    OP_STORE = 4'd3,
    OP_JUMP  = 4'd4,
    OP_DIV   = 4'd5,
    OP_HALT  = 4'd6
  } opcode_e;

  function automatic logic src_hit(input sb_entry_t e,
                                   input logic [SB_RD_W-1:0] rs1,
                                   input logic [SB_RD_W-1:0] rs2);
    return e.valid && ((e.rd == rs1) || (e.rd == rs2));
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Two-deep record of in-flight register writers (EX and MEM stages).
//   Ports:
//     clk, rst     clock, async active-high reset (all entries invalid)
//     advance      shift: issue_entry -> EX, EX -> MEM; low freezes both
//     clear_ex     with advance, EX loads a bubble instead of issue_entry
//     issue_entry  entry for the instruction leaving ID (bubble if none)
//     ex_entry     current EX-stage entry
//     mem_entry    current MEM-stage entry
module hazard_scoreboard
  import hazard_scheduler_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      advance,
  input  logic      clear_ex,
  input  sb_entry_t issue_entry,
  output sb_entry_t ex_entry,
  output sb_entry_t mem_entry
);

  sb_entry_t ex_q, ex_d;
  sb_entry_t mem_q, mem_d;

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    if (advance) begin
      mem_d = ex_q;
      ex_d  = clear_ex ? SB_BUBBLE : issue_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= SB_BUBBLE;
      mem_q <= SB_BUBBLE;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
    end
  end

  assign ex_entry  = ex_q;
  assign mem_entry = mem_q;

endmodule

// File: rtl/hazard_scheduler.sv
// hazard_scheduler
//   Pipeline hazard/stall controller: load-use and RAW stalls, taken-branch
//   flush, multi-cycle DIV occupancy and HALT/resume.
//   Build option: HAZARD_FORWARD_EN -- when defined only load-use stalls
//   (ALU results are forwarded); when undefined any source matching a
//   reg-writing EX or MEM entry stalls.
//   Ports:
//     clk, rst                       clock, async active-high reset
//     id_valid                       ID holds a real instruction
//     id_reg_write/mem_read/jump/
//     inc_pc/is_div                  ID decode bits (inc_pc=0 is HALT)
//     id_rd, id_rs1, id_rs2          ID register addresses
//     branch_taken                   EX resolved a taken jump/branch
//     resume                         restart from HALT
//     pc_write, ifid_write           PC / IF-ID load enables
//     idex_bubble, flush             NOP into ID/EX, clear IF/ID + ID/EX
//     halted, div_busy, state        status
//
//   state    | meaning
//   RUN      | normal issue, stalls on data hazards
//   DIV_WAIT | DIV occupying EX, pipeline frozen until counter expires
//   HALT     | stopped, waiting for resume (or a taken branch)
//   FLUSH    | one cycle after a taken branch, wrong-path work discarded
module hazard_scheduler
  import hazard_scheduler_pkg::*;
#(
  parameter int REG_AW     = 3,
  parameter int DIV_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_jump,
  input  logic              id_inc_pc,
  input  logic              id_is_div,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              branch_taken,
  input  logic              resume,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_bubble,
  output logic              flush,
  output logic              halted,
  output logic              div_busy,
  output logic [1:0]        state
);

  localparam logic [DIV_CNT_W-1:0] DIV_LOAD = DIV_CNT_W'(DIV_CYCLES - 1);

  sched_state_e          state_q, state_d;
  logic [DIV_CNT_W-1:0]  div_cnt_q, div_cnt_d;

  sb_entry_t             ex_entry, mem_entry, issue_entry;
  logic                  issue, sb_advance, sb_clear_ex;
  logic [SB_RD_W-1:0]    rd_ext, rs1_ext, rs2_ext;
  logic                  ex_hit, data_stall;

  // Jumps resolve in EX and arrive as branch_taken; the ID bit is not needed.
  logic unused_id_jump;
  assign unused_id_jump = id_jump;

  assign rd_ext  = SB_RD_W'(id_rd);
  assign rs1_ext = SB_RD_W'(id_rs1);
  assign rs2_ext = SB_RD_W'(id_rs2);

  assign ex_hit = src_hit(ex_entry, rs1_ext, rs2_ext);

`ifdef HAZARD_FORWARD_EN
  logic unused_mem_entry;
  assign unused_mem_entry = ^mem_entry;
  assign data_stall = id_valid && ex_hit && ex_entry.is_load;
`else
  // A load in MEM is returning its data this cycle, so only the EX-stage
  // load needs to hold ID; ALU writers stall in both EX and MEM.
  logic mem_hit;
  assign mem_hit    = src_hit(mem_entry, rs1_ext, rs2_ext) && !mem_entry.is_load;
  assign data_stall = id_valid && (ex_hit || mem_hit);
`endif

  // Only register writers can create hazards, so non-writers enter as bubbles.
  always_comb begin
    issue_entry = SB_BUBBLE;
    if (issue && id_reg_write) begin
      issue_entry.valid   = 1'b1;
      issue_entry.rd      = rd_ext;
      issue_entry.is_load = id_mem_read;
    end
  end

  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    flush       = 1'b0;
    halted      = 1'b0;
    div_busy    = 1'b0;
    issue       = 1'b0;
    sb_advance  = 1'b1;
    sb_clear_ex = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (branch_taken) begin
          ifid_write  = 1'b0;
          flush       = 1'b1;
          sb_clear_ex = 1'b1;
          state_d     = ST_FLUSH;
        end else if (data_stall) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end else begin
          issue = id_valid;
          if (id_valid && id_is_div) begin
            div_cnt_d = DIV_LOAD;
            state_d   = ST_DIV_WAIT;
          end else if (id_valid && !id_inc_pc) begin
            state_d = ST_HALT;
          end
        end
      end

      // The DIV itself sits in EX, so a branch cannot resolve here.
      ST_DIV_WAIT: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        div_busy   = 1'b1;
        sb_advance = 1'b0;
        if (div_cnt_q != '0) begin
          div_cnt_d = div_cnt_q - DIV_CNT_W'(1);
        end
        if (div_cnt_q <= DIV_CNT_W'(1)) begin
          state_d = ST_RUN;
        end
      end

      ST_HALT: begin
        if (branch_taken) begin
          ifid_write  = 1'b0;
          flush       = 1'b1;
          sb_clear_ex = 1'b1;
          state_d     = ST_FLUSH;
        end else begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          halted      = 1'b1;
          if (resume) begin
            state_d = ST_RUN;
          end
        end
      end

      ST_FLUSH: begin
        ifid_write  = 1'b0;
        flush       = 1'b1;
        sb_clear_ex = 1'b1;
        state_d     = branch_taken ? ST_FLUSH : ST_RUN;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Outputs follow reset without waiting for a clock edge.
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      flush       = 1'b0;
      halted      = 1'b0;
      div_busy    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      div_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  assign state = state_q;

  hazard_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .advance     (sb_advance),
    .clear_ex    (sb_clear_ex),
    .issue_entry (issue_entry),
    .ex_entry    (ex_entry),
    .mem_entry   (mem_entry)
  );

endmodule

// File: tb/tb_hazard_scheduler.sv
// tb_hazard_scheduler
//   Directed scenarios for hazard_scheduler (default build, DIV_CYCLES=8).
//   The driver pushes the hand-computed expected output vector for every
//   cycle it drives; a monitor pops and compares on the falling edge.
//   Output vector: {pc_write, ifid_write, idex_bubble, flush, halted,
//   div_busy, state[1:0]}.
module tb_hazard_scheduler;

  logic       clk;
  logic       rst;
  logic       id_valid, id_reg_write, id_mem_read, id_jump, id_inc_pc, id_is_div;
  logic [2:0] id_rd, id_rs1, id_rs2;
  logic       branch_taken, resume;
  logic       pc_write, ifid_write, idex_bubble, flush, halted, div_busy;
  logic [1:0] state;

  localparam logic [7:0] O_RUN     = 8'b1100_0000;
  localparam logic [7:0] O_STALL   = 8'b0010_0000;
  localparam logic [7:0] O_RST     = 8'b0010_0000;
  localparam logic [7:0] O_BR_RUN  = 8'b1001_0000;
  localparam logic [7:0] O_FLUSH   = 8'b1001_0011;
  localparam logic [7:0] O_DIV     = 8'b0000_0101;
  localparam logic [7:0] O_HALT    = 8'b0010_1010;
  localparam logic [7:0] O_BR_HALT = 8'b1001_0010;

  hazard_scheduler #(.REG_AW(3), .DIV_CYCLES(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .id_jump      (id_jump),
    .id_inc_pc    (id_inc_pc),
    .id_is_div    (id_is_div),
    .id_rd        (id_rd),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .branch_taken (branch_taken),
    .resume       (resume),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .idex_bubble  (idex_bubble),
    .flush        (flush),
    .halted       (halted),
    .div_busy     (div_busy),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] exp_q[$];
  string      name_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  logic [7:0] act;
  logic [7:0] mon_exp;
  string      mon_name;
  assign act = {pc_write, ifid_write, idex_bubble, flush, halted, div_busy, state};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      n_checks++;
      if (act !== mon_exp) begin
        n_fail++;
        $display("FAIL %s: outputs %b, expected %b", mon_name, act, mon_exp);
      end
    end
  end

  task automatic cyc(input string nm, input logic r, input logic v,
                     input logic rw, input logic mr, input logic dv,
                     input logic hlt, input int rd, input int rs1, input int rs2,
                     input logic br, input logic res, input logic [7:0] e);
    @(posedge clk);
    #1;
    rst          = r;
    id_valid     = v;
    id_reg_write = rw;
    id_mem_read  = mr;
    id_jump      = 1'b0;
    id_inc_pc    = ~hlt;
    id_is_div    = dv;
    id_rd        = 3'(rd);
    id_rs1       = 3'(rs1);
    id_rs2       = 3'(rs2);
    branch_taken = br;
    resume       = res;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic nop(input string nm, input logic [7:0] e);
    cyc(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_reg_write = 1'b0; id_mem_read = 1'b0;
    id_jump = 1'b0; id_inc_pc = 1'b1; id_is_div = 1'b0;
    id_rd = '0; id_rs1 = '0; id_rs2 = '0; branch_taken = 1'b0; resume = 1'b0;

    // reset state, then release
    cyc("reset_0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST);
    cyc("reset_br", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_RST);
    nop("after_reset", O_RUN);

    // LOAD r2 ; ADD r3,r2,r1 -> one stall
    cyc("load_r2", 0, 1, 1, 1, 0, 0, 2, 0, 0, 0, 0, O_RUN);
    cyc("load_use_stall", 0, 1, 1, 0, 0, 0, 3, 2, 1, 0, 0, O_STALL);
    cyc("load_use_issue", 0, 1, 1, 0, 0, 0, 3, 2, 1, 0, 0, O_RUN);
    nop("drain_0", O_RUN);
    nop("drain_1", O_RUN);

    // ADD r2 ; SUB r4,r2,r1 -> two stalls without forwarding
    cyc("add_r2", 0, 1, 1, 0, 0, 0, 2, 5, 6, 0, 0, O_RUN);
    cyc("raw_ex_stall", 0, 1, 1, 0, 0, 0, 4, 2, 1, 0, 0, O_STALL);
    cyc("raw_mem_stall", 0, 1, 1, 0, 0, 0, 4, 2, 1, 0, 0, O_STALL);
    cyc("raw_issue", 0, 1, 1, 0, 0, 0, 4, 2, 1, 0, 0, O_RUN);
    // rs2 dependency on the SUB
    cyc("rs2_ex_stall", 0, 1, 1, 0, 0, 0, 5, 1, 4, 0, 0, O_STALL);
    cyc("rs2_mem_stall", 0, 1, 1, 0, 0, 0, 5, 1, 4, 0, 0, O_STALL);
    cyc("rs2_issue", 0, 1, 1, 0, 0, 0, 5, 1, 4, 0, 0, O_RUN);
    nop("drain_2", O_RUN);
    nop("drain_3", O_RUN);

    // DIV: 7 busy cycles, branch_taken ignored while busy
    cyc("div_issue", 0, 1, 1, 0, 1, 0, 6, 1, 2, 0, 0, O_RUN);
    for (int i = 0; i < 7; i++) begin
      cyc($sformatf("div_wait_%0d", i), 0, 0, 0, 0, 0, 0, 0, 0, 0, (i == 1), 0, O_DIV);
    end
    nop("div_done", O_RUN);

    // branch coincident with a load-use stall
    cyc("load_r7", 0, 1, 1, 1, 0, 0, 7, 0, 0, 0, 0, O_RUN);
    cyc("branch_over_stall", 0, 1, 1, 0, 0, 0, 1, 7, 0, 1, 0, O_BR_RUN);
    cyc("flush_state", 0, 1, 1, 0, 0, 0, 1, 7, 0, 0, 0, O_FLUSH);
    cyc("after_flush", 0, 1, 1, 0, 0, 0, 1, 7, 0, 0, 0, O_RUN);
    nop("drain_4", O_RUN);

    // HALT held for 20 cycles, then resume
    cyc("halt_issue", 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, O_RUN);
    for (int i = 0; i < 20; i++) begin
      nop($sformatf("halt_hold_%0d", i), O_HALT);
    end
    cyc("halt_resume", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_HALT);
    cyc("resume_in_run", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_RUN);
    nop("still_run", O_RUN);

    // taken branch exits HALT through FLUSH
    cyc("halt_issue_2", 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, O_RUN);
    cyc("branch_in_halt", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_BR_HALT);
    nop("halt_flush", O_FLUSH);
    nop("halt_flush_run", O_RUN);

    // reset asserted when DIV counter reaches 4
    cyc("div_issue_2", 0, 1, 1, 0, 1, 0, 6, 0, 0, 0, 0, O_RUN);
    nop("div2_cnt7", O_DIV);
    nop("div2_cnt6", O_DIV);
    nop("div2_cnt5", O_DIV);
    cyc("div2_reset_async", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST);
    cyc("div2_reset_hold", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST);
    nop("div2_release", O_RUN);
    nop("div2_run", O_RUN);

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scheduler.md
HAZARD_SCHEDULER -- requirements
Module: hazard_scheduler

Interface
REQ-001 SHALL have parameter REG_AW, default 3, register-address width (8 GPRs).
REQ-002 SHALL have parameter DIV_CYCLES, default 8, total EX occupancy of DIV in cycles (range 2..15).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 id_valid  input  1  ID stage holds a real instruction.
REQ-006 id_reg_write, id_mem_read, id_jump, id_inc_pc, id_is_div  input  1 each  decoded control bits of ID instruction; id_inc_pc=0 means HALT.
REQ-007 id_rd, id_rs1, id_rs2  input  REG_AW each  ID destination and sources.
REQ-008 branch_taken  input  1  EX-stage resolved taken jump/branch.
REQ-009 resume  input  1  external restart from HALT.
REQ-010 pc_write  output  1  PC update enable.
REQ-011 ifid_write  output  1  IF/ID register load enable.
REQ-012 idex_bubble  output  1  insert NOP into ID/EX.
REQ-013 flush  output  1  clear IF/ID and ID/EX.
REQ-014 halted, div_busy  output  1 each  status.
REQ-015 state  output  2  current FSM state code.

Function
REQ-016 SHALL implement FSM RUN=0, DIV_WAIT=1, HALT=2, FLUSH=3.
REQ-017 Scoreboard SHALL hold EX and MEM entries {valid, rd, is_load}; each cycle ID issue (id_valid, no stall, no flush) shifts into EX, EX into MEM; a bubble shifts in valid=0.
REQ-018 Load-use: EX entry valid, is_load, and rd equal to id_rs1 or id_rs2 with id_valid SHALL assert for exactly one cycle pc_write=0, ifid_write=0, idex_bubble=1.
REQ-019 RUN with no hazard SHALL drive pc_write=1, ifid_write=1, idex_bubble=0, flush=0.
REQ-020 branch_taken SHALL assert flush in the same cycle combinationally, move to FLUSH for one cycle (flush=1, pc_write=1), then RUN; scoreboard EX entry cleared.
REQ-021 Issue of id_is_div SHALL load a 4-bit counter with DIV_CYCLES-1 and enter DIV_WAIT; while counter nonzero pc_write=0, ifid_write=0, idex_bubble=0, div_busy=1, scoreboard frozen; counter decrements per cycle; at zero return to RUN next cycle.
REQ-022 Issue of HALT (id_valid, id_inc_pc=0) SHALL enter HALT next cycle: pc_write=0, ifid_write=0, idex_bubble=1, halted=1; resume=1 returns to RUN next cycle.
REQ-023 Priority SHALL be rst > branch_taken > DIV_WAIT > HALT > data stall > normal issue.
REQ-024 branch_taken during DIV_WAIT SHALL be ignored (EX frozen cannot resolve); branch_taken in HALT SHALL exit to FLUSH.
REQ-025 resume outside HALT SHALL have no effect.

Reset
REQ-026 While rst=1: state=RUN, pc_write=0, ifid_write=0, idex_bubble=1, flush=0, halted=0, div_busy=0, counter=0, scoreboard invalid.
REQ-027 Reset asserted mid-DIV_WAIT or HALT SHALL abort immediately; first cycle after release is RUN.

Configuration
REQ-028 Macro HAZARD_FORWARD_EN defined: only load-use (REQ-018) stalls; ALU results assumed forwarded.
REQ-029 Macro undefined: any source matching a valid reg-writing EX or MEM entry SHALL stall (same outputs as REQ-018), repeating until cleared (max 2 cycles).

Structure
REQ-030 FSM state codes, scoreboard entry struct and DIV counter width SHALL live in the shared parameters package alongside the opcode definitions.
REQ-031 Scoreboard SHALL be one sub-module, hazard_scoreboard; FSM and output decode stay in the top.

Verification
REQ-032 LOAD r2 then ADD r3,r2,r1 -> one stall cycle (pc_write=0, idex_bubble=1), then issue; both macro settings.
REQ-033 ADD r2 then SUB r4,r2,r1 -> no stall with HAZARD_FORWARD_EN; 2 stall cycles without it.
REQ-034 DIV issue, DIV_CYCLES=8 -> div_busy=1 for 7 cycles, state=1, then RUN.
REQ-035 branch_taken coincident with load-use stall -> flush=1, no bubble-only stall, state=3 for one cycle.
REQ-036 HALT issue -> halted=1 from next cycle; resume held 0 for 20 cycles keeps HALT; resume=1 -> RUN next cycle.
REQ-037 rst pulse at DIV count 4 -> outputs at reset values asynchronously, RUN after release, div_busy=0.
